// File: rtl/burst_rr_arbiter.sv
// Burst-mode round-robin arbiter: merges WIDTH first-word-fall-through sources into one
// registered write stream, with per-grant burst limit and HOLD_REQ record locking.
module burst_rr_arbiter #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST_N,
  input  logic                   ENABLE,
  input  logic [WIDTH-1:0]       WRITE_REQ,
  input  logic [WIDTH-1:0]       HOLD_REQ,
  input  logic [WIDTH*DSIZE-1:0] DATA_IN,
  input  logic                   READY_IN,
  output logic [WIDTH-1:0]       READ_GRANT,
  output logic                   WRITE_OUT,
  output logic [DSIZE-1:0]       DATA_OUT,
  output logic [7:0]             GRANT_ID,
  output logic                   BUSY
);

  localparam int unsigned IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]  LAST_INIT  = 8'(WIDTH - 1);
  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  // sel_q doubles as the rotation pointer: it always equals "last" whenever the FSM is idle
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             write_out_q, write_out_d;
  logic [DSIZE-1:0] data_out_q, data_out_d;

  logic [DSIZE-1:0] words [WIDTH];
  logic             sel_req, sel_hold, pop, found;
  logic [7:0]       cand, next_sel;
  logic [WIDTH-1:0] read_grant;

  for (genvar g = 0; g < WIDTH; g++) begin : g_words
    assign words[g] = DATA_IN[g*DSIZE +: DSIZE];
  end

  assign sel_req  = WRITE_REQ[sel_q[IW-1:0]];
  assign sel_hold = HOLD_REQ[sel_q[IW-1:0]];

  // First requester after the pointer, wrapping modulo WIDTH.
  always_comb begin
    found    = 1'b0;
    next_sel = sel_q;
    cand     = '0;
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      cand = 8'((32'(sel_q) + k) % WIDTH);
      if (!found && WRITE_REQ[cand[IW-1:0]]) begin
        found    = 1'b1;
        next_sel = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE && found) begin
          sel_d   = next_sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pop = sel_req & READY_IN & ENABLE;
        if (pop && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        if (!ENABLE || (!sel_req && !sel_hold) ||
            (pop && !sel_hold && (cnt_q >= BURST_LAST))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_grant = '0;
    if (pop) read_grant[sel_q[IW-1:0]] = 1'b1;
    write_out_d = pop;
    data_out_d  = pop ? words[sel_q[IW-1:0]] : data_out_q;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q     <= IDLE;
      sel_q       <= LAST_INIT;
      cnt_q       <= '0;
      write_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      write_out_q <= write_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign READ_GRANT = read_grant;
  assign WRITE_OUT  = write_out_q;
  assign DATA_OUT   = data_out_q;
  assign GRANT_ID   = sel_q;
  assign BUSY       = (state_q == GRANT);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Scoreboard bench for burst_rr_arbiter: queue-based source model, transaction-level
// round-robin reference, and a negedge monitor comparing every WRITE_OUT word.
module tb_burst_rr_arbiter;

  localparam int unsigned W  = 6;
  localparam int unsigned DS = 32;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, ready;
  logic [W-1:0]  wreq, hold, rgrant;
  logic [W*DS-1:0] din;
  logic          wout, busy;
  logic [DS-1:0] dout;
  logic [7:0]    gid;

  burst_rr_arbiter #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(MB)) u_dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(en), .WRITE_REQ(wreq), .HOLD_REQ(hold),
    .DATA_IN(din), .READY_IN(ready), .READ_GRANT(rgrant), .WRITE_OUT(wout),
    .DATA_OUT(dout), .GRANT_ID(gid), .BUSY(busy)
  );

  // Second instance: MAX_BURST=1, every source permanently non-empty, word = source index.
  logic            rst1_n;
  logic [W-1:0]    rgrant1;
  logic            wout1, busy1;
  logic [DS-1:0]   dout1;
  logic [7:0]      gid1;
  logic [W*DS-1:0] din1;

  burst_rr_arbiter #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(1)) u_dut1 (
    .BUS_CLK(clk), .BUS_RST_N(rst1_n), .ENABLE(1'b1), .WRITE_REQ({W{1'b1}}),
    .HOLD_REQ({W{1'b0}}), .DATA_IN(din1), .READY_IN(1'b1), .READ_GRANT(rgrant1),
    .WRITE_OUT(wout1), .DATA_OUT(dout1), .GRANT_ID(gid1), .BUSY(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int scn     = 0;

  logic [DS-1:0] src_q [W][$];
  logic [DS-1:0] m_q   [W][$];
  logic [DS-1:0] exp_q [$];
  logic [DS-1:0] exp1_q [$];
  bit            hold_en [W];
  bit            hold_m  [W];
  int            last_m;
  int unsigned   ready_pct;
  bit            ready_toggle;
  logic [W-1:0]  last_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit any_src();
    bit r = 1'b0;
    for (int i = 0; i < W; i++) if (src_q[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < W; i++) begin
      wreq[i] = (src_q[i].size() != 0);
      hold[i] = hold_en[i] && (src_q[i].size() != 0);
      din[i*DS +: DS] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
    if (ready_toggle) ready = ~ready;
    else              ready = ($urandom_range(99) < ready_pct);
  endtask

  // One clock: record the grant presented this cycle, then consume it from the source.
  task automatic step();
    @(negedge clk);
    last_g = rgrant;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++)
      if (last_g[i] && (src_q[i].size() != 0)) void'(src_q[i].pop_front());
    apply_inputs();
  endtask

  task automatic load(input int src, input int n);
    for (int k = 0; k < n; k++) src_q[src].push_back({8'(src), 8'(scn), 16'(k)});
  endtask

  task automatic sync_model();
    for (int i = 0; i < W; i++) begin
      m_q[i]    = src_q[i];
      hold_m[i] = hold_en[i];
    end
  endtask

  function automatic int next_src();
    int f = -1;
    for (int k = 1; k <= W; k++) begin
      int c = (last_m + k) % W;
      if (f < 0 && m_q[c].size() != 0) f = c;
    end
    return f;
  endfunction

  // Reference: rotate over non-empty sources; a held source drains fully, others give up to MB words.
  task automatic model_run();
    int f, n;
    f = next_src();
    while (f >= 0) begin
      n = hold_m[f] ? m_q[f].size() : ((m_q[f].size() < MB) ? m_q[f].size() : MB);
      for (int k = 0; k < n; k++) exp_q.push_back(m_q[f].pop_front());
      last_m = f;
      f = next_src();
    end
  endtask

  task automatic drain(input string name);
    int budget = 3000;
    while ((any_src() || exp_q.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
    chk({name, "_budget_ok"}, 64'(budget != 0), 64'd1);
    chk({name, "_all_words_out"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Main monitor.
  logic prev_g = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_g = 1'b0;
      end else begin
        chk("wout_latency", 64'(wout), 64'(prev_g));
        chk("grant_onehot0", 64'($onehot0(rgrant)), 64'd1);
        if (!en) chk("no_grant_disabled", 64'(rgrant), 64'd0);
        if (wout) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_word: got %0h required no word (t=%0t)", dout, $time);
          end else begin
            chk("data_out", 64'(dout), 64'(exp_q.pop_front()));
          end
        end
        prev_g = |rgrant;
      end
    end
  end

  // MAX_BURST=1 monitor.
  logic prev1 = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst1_n && exp1_q.size() != 0) begin
        if (wout1) begin
          chk("mb1_idle_gap", 64'(prev1), 64'd0);
          chk("mb1_order", 64'(dout1), 64'(exp1_q.pop_front()));
        end
        prev1 = wout1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, pops, budget;
    rst_n = 1'b0; rst1_n = 1'b0; en = 1'b1; ready = 1'b1;
    ready_pct = 100; ready_toggle = 1'b0;
    for (int i = 0; i < W; i++) begin
      hold_en[i] = 1'b0;
      din1[i*DS +: DS] = DS'(i);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < W; i++) exp1_q.push_back(DS'(i));
    apply_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wout", 64'(wout), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(rgrant), 64'd0);
    chk("rst_gid", 64'(gid), 64'd5);
    rst_n = 1'b1; rst1_n = 1'b1;
    last_m = W - 1;

    // Two sources of 10 words, burst limit 4.
    scn = 1;
    load(1, 10); load(3, 10); apply_inputs();
    sync_model(); model_run(); drain("basic");

    // Held 20-word record on source 0 competing with source 2.
    scn = 2;
    hold_en[0] = 1'b1;
    load(0, 20); load(2, 6); apply_inputs();
    sync_model(); model_run(); drain("hold");
    hold_en[0] = 1'b0;

    // READY_IN alternating every cycle.
    scn = 3;
    ready_toggle = 1'b1;
    load(2, 9); load(5, 7); apply_inputs();
    sync_model(); model_run(); drain("stall");
    ready_toggle = 1'b0; ready = 1'b1;

    // ENABLE dropped after the second word of a held burst.
    scn = 4;
    hold_en[1] = 1'b1; hold_en[4] = 1'b1;
    load(1, 4); load(4, 3); apply_inputs();
    sync_model();
    f = next_src();
    for (int k = 0; k < 2; k++) exp_q.push_back(m_q[f].pop_front());
    last_m = f;
    for (int i = 0; i < W; i++) hold_m[i] = 1'b0;
    model_run();
    pops = 0; budget = 50;
    while (pops < 2 && budget > 0) begin
      step();
      if (last_g != '0) pops++;
      budget--;
    end
    chk("en_two_pops", 64'(pops), 64'd2);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("en_low_no_grant", 64'(last_g), 64'd0);
      chk("en_low_idle", 64'(busy), 64'd0);
      chk("en_low_gid_hold", 64'(gid), 64'(f));
    end
    hold_en[1] = 1'b0; hold_en[4] = 1'b0;
    en = 1'b1; apply_inputs();
    drain("enable");

    // Asynchronous reset in the middle of a burst; second word is in the output register.
    scn = 5;
    load(3, 8); apply_inputs();
    exp_q.push_back(src_q[3][0]);
    pops = 0; budget = 50;
    while (pops < 2 && budget > 0) begin
      step();
      if (last_g != '0) pops++;
      budget--;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wout", 64'(wout), 64'd0);
    chk("arst_dout", 64'(dout), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(rgrant), 64'd0);
    chk("arst_gid", 64'(gid), 64'd5);
    chk("arst_first_word_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    load(0, 1); load(4, 1); apply_inputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    last_m = W - 1;
    sync_model(); model_run(); drain("after_reset");

    // Randomized mixes of depths, holds and back-pressure.
    for (int r = 0; r < 6; r++) begin
      scn = 10 + r;
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < W; i++) begin
        hold_en[i] = ($urandom_range(3) == 0);
        load(i, $urandom_range(0, 9));
      end
      apply_inputs();
      sync_model(); model_run(); drain("random");
    end

    chk("mb1_sequence_done", 64'(exp1_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
